pi_loop_filter: RTL and testbench
=================================

// Module: pi_loop_filter
// PURPOSE
//  Carrier-recovery PI loop filter, downstream of the decision-directed phase detector.
//  Takes phase_err/err_valid at the symbol rate and outputs a signed NCO frequency-control word.
//  Gains switch automatically: wide gains in ACQ, narrow gains in TRACK.
//  The switch is driven by an |err|-threshold lock detector.
// PARAMETERS
//  EW          24  phase-error width, Q2.(EW-2), signed
//  FW          32  frequency-word / integrator width, signed
//  LOCK_CNT    64  consecutive in-threshold errors needed to enter TRACK
//  UNLOCK_CNT  16  consecutive out-of-threshold errors needed to return to ACQ
// PORTS
//  clk          in   1       sample clock (200 MHz)
//  rst_n        in   1       asynchronous, active-low reset
//  err_valid    in   1       phase_err qualifier, 1-cycle strobe
//  phase_err    in   EW      signed phase error
//  kp_acq_sh    in   5       proportional right-shift, ACQ state
//  ki_acq_sh    in   5       integral right-shift, ACQ state
//  kp_trk_sh    in   5       proportional right-shift, TRACK state
//  ki_trk_sh    in   5       integral right-shift, TRACK state
//  lock_thresh  in   EW-1    unsigned |err| lock threshold
//  integ_clr    in   1       synchronous integrator clear; also forces ACQ
//  integ_frz    in   1       hold integrator (proportional path stays live)
//  freq_valid   out  1       freq_word strobe
//  freq_word    out  FW      signed NCO frequency word
//  locked       out  1       1 while in TRACK
// BEHAVIOUR
//  Reset (async assert, sync deassert): integ=0, freq_word=0, freq_valid=0, locked=0.
//    Reset also sets state=ACQ and clears both counters. A reset mid-pipeline drops in-flight samples.
//  Arithmetic:
//    e_ext = sext(phase_err,FW) <<< (FW-EW).
//    p = e_ext >>> kp_sh; inc = e_ext >>> ki_sh (arithmetic shifts).
//    A shift >= FW yields 0 or -1 per sign.
//    integ_n = sat_FW(integ + inc), computed at FW+1 bits.
//    freq_word = sat_FW(integ_n + p); saturation clamps to +/-(2^(FW-1)-1), never wraps.
//  Latency: err_valid at cycle t -> freq_valid=1 at t+2 for exactly one cycle.
//    Stage 1 (t+1): register p, inc, |err|, and the gain selection.
//    Stage 2 (t+2): integrator and output update.
//    err_valid may assert every cycle; full throughput, no backpressure.
//  freq_word holds its value between strobes.
//  |err|: abs(-2^(EW-1)) saturates to 2^(EW-1)-1. "In" means |err| <= lock_thresh.
//  FSM, evaluated at stage 1 of each valid sample:
//    ACQ:   in-sample increments in_cnt, an out-sample clears it.
//           in_cnt reaching LOCK_CNT -> TRACK; clears both counters.
//    TRACK: out-sample increments out_cnt, an in-sample clears it.
//           out_cnt reaching UNLOCK_CNT -> ACQ; clears both counters.
//    Counters saturate at their limit.
//  The gains for a sample come from the state before that sample's FSM update.
//    A new state therefore takes effect on the next sample.
//  locked = (state==TRACK), registered.
//  integ_frz=1 during stage 2: integ unchanged; freq_word = sat_FW(integ + p).
//  integ_clr=1 (any cycle): integ=0, state=ACQ, counters cleared.
//    Coincident with a stage-2 update: clear wins, freq_word = sat_FW(p).
//    Coincident with a stage-1 evaluation: the FSM update is discarded.
//  clr has priority over frz.
// CONFIGURATION
//  LF_DBG_EN defined: adds integ_dbg (out, FW) = integ register.
//    Also adds sat_cnt (out, 16): counts saturating integrator updates, saturates at 0xFFFF,
//    and is cleared by reset or integ_clr.
//  LF_DBG_EN undefined: neither port exists, no extra logic; core behaviour is identical.
// STRUCTURE
//  Package msk_loop_pkg: typedef enum logic {LF_ACQ, LF_TRACK} lf_state_e; function sat_fw().
//  Sub-module lf_lock_detect: |err| compare, in_cnt/out_cnt, FSM, locked output.
//  Top level: shift/accumulate datapath and pipeline registers.
// TESTING
//  1. Reset with err_valid=1 and phase_err=0x100000:
//     -> freq_valid=0, freq_word=0, locked=0 throughout reset.
//  2. ACQ, kp_acq_sh=4, ki_acq_sh=8, single err=0x000100 at t:
//     -> freq_valid at t+2; freq_word = 0x10000>>4 + 0x10000>>8 = 0x1100.
//  3. lock_thresh=0x40, 64 errors of +/-0x20: locked rises after the 64th.
//     -> 65th sample uses the TRACK shifts. Then 16 errors of 0x1000 -> locked falls.
//  4. Repeated err=0x7FFFFF with ki_sh=0 -> freq_word clamps at 0x7FFFFFFF, no wrap.
//     Repeat with err=0x800000 -> clamps at 0x80000001.
//  5. integ_frz=1 with err=0x100 repeated -> freq_word constant at integ + p.
//     Pulse integ_clr in the same cycle as a stage-2 update -> integ=0, freq_word=p, locked=0.
//  6. Back-to-back err_valid on 3 consecutive cycles -> 3 consecutive freq_valid pulses.
//     Assert rst_n mid-burst -> outputs go to 0 asynchronously; no pulse after release.

Source files
------------

// File: rtl/msk_loop_pkg.sv
// Shared types and saturation helper for the carrier-recovery PI loop filter.
package msk_loop_pkg;

    typedef enum logic {LF_ACQ = 1'b0, LF_TRACK = 1'b1} lf_state_e;

    // Symmetric clamp to +/-(2^(fw-1)-1); callers sign-extend into 64 bits and narrow the result.
    function automatic logic signed [63:0] sat_fw(input logic signed [63:0] x, input int unsigned fw);
        logic signed [63:0] mx;
        mx = (64'sd1 <<< (fw - 1)) - 64'sd1;
        if (x > mx) return mx;
        if (x < -mx) return -mx;
        return x;
    endfunction

endpackage

// File: rtl/lf_lock_detect.sv
// Lock detector: |err| threshold compare, consecutive in/out counters, ACQ/TRACK state.
module lf_lock_detect
    import msk_loop_pkg::*;
#(
    parameter int EW         = 24,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [EW-1:0] i_err,
    input  logic [EW-2:0] i_thresh,
    input  logic          i_clr,
    output logic          o_locked
);

    localparam int CW = $clog2((LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1);

    lf_state_e     r_state;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] r_out_cnt;
    logic          r_locked;
    logic [EW-1:0] w_neg;
    logic [EW-2:0] w_abs;
    logic          w_in;

    assign w_neg = -i_err;

    // The most negative input negates to itself; clamp it to the largest magnitude.
    always_comb begin
        w_abs = i_err[EW-2:0];
        if (i_err[EW-1]) w_abs = w_neg[EW-1] ? '1 : w_neg[EW-2:0];
    end

    assign w_in = (w_abs <= i_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LF_ACQ;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_locked  <= 1'b0;
        end else if (i_clr) begin
            r_state   <= LF_ACQ;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_locked  <= 1'b0;
        end else if (i_valid) begin
            unique case (r_state)
                LF_ACQ: begin
                    if (!w_in) begin
                        r_in_cnt <= '0;
                    end else if (r_in_cnt + 1'b1 == CW'(LOCK_CNT)) begin
                        r_state   <= LF_TRACK;
                        r_locked  <= 1'b1;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                    end else begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                    end
                end
                LF_TRACK: begin
                    if (w_in) begin
                        r_out_cnt <= '0;
                    end else if (r_out_cnt + 1'b1 == CW'(UNLOCK_CNT)) begin
                        r_state   <= LF_ACQ;
                        r_locked  <= 1'b0;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                    end else begin
                        r_out_cnt <= r_out_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_locked = r_locked;

endmodule

// File: rtl/pi_loop_filter.sv
// Carrier-recovery PI loop filter with ACQ/TRACK gain switching.
// Optional debug ports (integ_dbg, sat_cnt) are enabled by defining LF_DBG_EN.
module pi_loop_filter
    import msk_loop_pkg::*;
#(
    parameter int EW         = 24,
    parameter int FW         = 32,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          err_valid,
    input  logic [EW-1:0] phase_err,
    input  logic [4:0]    kp_acq_sh,
    input  logic [4:0]    ki_acq_sh,
    input  logic [4:0]    kp_trk_sh,
    input  logic [4:0]    ki_trk_sh,
    input  logic [EW-2:0] lock_thresh,
    input  logic          integ_clr,
    input  logic          integ_frz,
    output logic          freq_valid,
    output logic [FW-1:0] freq_word,
    output logic          locked
`ifdef LF_DBG_EN
    ,
    output logic [FW-1:0] integ_dbg,
    output logic [15:0]   sat_cnt
`endif
);

    logic signed [FW-1:0] w_e_ext;
    logic signed [FW-1:0] w_p;
    logic signed [FW-1:0] w_inc;
    logic [4:0]           w_kp_sh;
    logic [4:0]           w_ki_sh;
    logic                 w_locked;
    logic signed [FW:0]   w_isum;
    logic signed [FW:0]   w_fsum;
    logic signed [FW-1:0] w_integ_n;
    logic signed [FW-1:0] w_base;
    logic signed [FW-1:0] w_freq_n;

    logic                 r_s1_vld;
    logic signed [FW-1:0] r_p;
    logic signed [FW-1:0] r_inc;
    logic signed [FW-1:0] r_integ;
    logic signed [FW-1:0] r_freq;
    logic                 r_fv;

    function automatic logic signed [FW-1:0] ashr(input logic signed [FW-1:0] x, input logic [4:0] sh);
        if (int'(sh) >= FW) return {FW{x[FW-1]}};
        return x >>> sh;
    endfunction

    assign w_e_ext = FW'($signed(phase_err)) <<< (FW - EW);

    // Gains follow the state before this sample's own lock-detector update.
    assign w_kp_sh = w_locked ? kp_trk_sh : kp_acq_sh;
    assign w_ki_sh = w_locked ? ki_trk_sh : ki_acq_sh;
    assign w_p     = ashr(w_e_ext, w_kp_sh);
    assign w_inc   = ashr(w_e_ext, w_ki_sh);

    lf_lock_detect #(
        .EW         (EW),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (err_valid),
        .i_err    (phase_err),
        .i_thresh (lock_thresh),
        .i_clr    (integ_clr),
        .o_locked (w_locked)
    );

    always_comb begin
        w_isum    = (FW+1)'(r_integ) + (FW+1)'(r_inc);
        w_integ_n = FW'(sat_fw(64'(w_isum), FW));
        if (integ_clr)      w_base = '0;
        else if (integ_frz) w_base = r_integ;
        else                w_base = w_integ_n;
        w_fsum   = (FW+1)'(w_base) + (FW+1)'(r_p);
        w_freq_n = FW'(sat_fw(64'(w_fsum), FW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_p      <= '0;
            r_inc    <= '0;
        end else begin
            r_s1_vld <= err_valid;
            if (err_valid) begin
                r_p   <= w_p;
                r_inc <= w_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_integ <= '0;
            r_freq  <= '0;
            r_fv    <= 1'b0;
        end else begin
            r_fv <= r_s1_vld;
            if (r_s1_vld) r_freq <= w_freq_n;
            if (integ_clr)                   r_integ <= '0;
            else if (r_s1_vld && !integ_frz) r_integ <= w_integ_n;
        end
    end

    assign freq_valid = r_fv;
    assign freq_word  = r_freq;
    assign locked     = w_locked;

`ifdef LF_DBG_EN
    logic [15:0] r_sat_cnt;
    logic        w_isat;

    assign w_isat = (64'(w_isum) != 64'(w_integ_n));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (integ_clr) begin
            r_sat_cnt <= '0;
        end else if (r_s1_vld && !integ_frz && w_isat && r_sat_cnt != 16'hFFFF) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign integ_dbg = r_integ;
    assign sat_cnt   = r_sat_cnt;
`endif

endmodule

// File: tb/tb_pi_loop_filter.sv
// Self-checking bench for pi_loop_filter against a longint arithmetic reference model.
module tb_pi_loop_filter;

    logic        clk;
    logic        rst_n;
    logic        err_valid;
    logic [23:0] phase_err;
    logic [4:0]  kp_acq_sh, ki_acq_sh, kp_trk_sh, ki_trk_sh;
    logic [22:0] lock_thresh;
    logic        integ_clr, integ_frz;
    logic        freq_valid;
    logic [31:0] freq_word;
    logic        locked;

    int n_checks = 0;
    int n_errors = 0;

    longint      m_integ;
    bit          m_trk;
    int          m_in, m_out;
    bit          pend_v;
    longint      pend_p, pend_inc;
    bit          exp_fv, exp_lk;
    logic [31:0] exp_fw;

    pi_loop_filter #(.EW(24), .FW(32), .LOCK_CNT(64), .UNLOCK_CNT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .err_valid   (err_valid),
        .phase_err   (phase_err),
        .kp_acq_sh   (kp_acq_sh),
        .ki_acq_sh   (ki_acq_sh),
        .kp_trk_sh   (kp_trk_sh),
        .ki_trk_sh   (ki_trk_sh),
        .lock_thresh (lock_thresh),
        .integ_clr   (integ_clr),
        .integ_frz   (integ_frz),
        .freq_valid  (freq_valid),
        .freq_word   (freq_word),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic longint sat(input longint x);
        longint mx;
        mx = 64'sd2147483647;
        if (x > mx) return mx;
        if (x < -mx) return -mx;
        return x;
    endfunction

    task automatic model_reset();
        m_integ = 0; m_trk = 0; m_in = 0; m_out = 0;
        pend_v = 0; pend_p = 0; pend_inc = 0;
        exp_fv = 0; exp_fw = '0; exp_lk = 0;
    endtask

    // Drives one cycle of inputs from a negedge, advances the model, and waits for the next negedge.
    task automatic step(input bit v, input logic [23:0] e, input bit frz, input bit clr);
        longint x, ee, p, inc, a, f;
        int kp, ki;
        bit in_thr;
        p = 0; inc = 0; f = 0;
        err_valid = v; phase_err = e; integ_frz = frz; integ_clr = clr;
        if (pend_v) begin
            if (clr) begin
                m_integ = 0;
                f = sat(pend_p);
            end else if (frz) begin
                f = sat(m_integ + pend_p);
            end else begin
                m_integ = sat(m_integ + pend_inc);
                f = sat(m_integ + pend_p);
            end
        end else if (clr) begin
            m_integ = 0;
        end
        if (v) begin
            kp = m_trk ? int'(kp_trk_sh) : int'(kp_acq_sh);
            ki = m_trk ? int'(ki_trk_sh) : int'(ki_acq_sh);
            x = longint'($signed(e));
            ee = x * 256;
            p = ee >>> kp;
            inc = ee >>> ki;
            a = (x < 0) ? -x : x;
            if (a > 64'sd8388607) a = 64'sd8388607;
            in_thr = (a <= longint'(lock_thresh));
            if (!m_trk) begin
                if (in_thr) begin
                    m_in++;
                    if (m_in == 64) begin m_trk = 1; m_in = 0; m_out = 0; end
                end else m_in = 0;
            end else begin
                if (!in_thr) begin
                    m_out++;
                    if (m_out == 16) begin m_trk = 0; m_in = 0; m_out = 0; end
                end else m_out = 0;
            end
        end
        if (clr) begin m_trk = 0; m_in = 0; m_out = 0; end
        @(negedge clk);
        exp_fv = pend_v;
        if (pend_v) exp_fw = 32'(f);
        pend_v = v; pend_p = p; pend_inc = inc;
        exp_lk = m_trk;
    endtask

    task automatic do_reset();
        err_valid = 0; integ_clr = 0; integ_frz = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        err_valid = 1; phase_err = 24'h100000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (freq_valid !== 1'b0 || freq_word !== 32'h0 || locked !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state cyc=%0d: got v=%0b w=%h lk=%0b, want 0/0/0", i, freq_valid, freq_word, locked);
            end
        end
        err_valid = 0;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        kp_acq_sh = 4; ki_acq_sh = 8; kp_trk_sh = 10; ki_trk_sh = 14; lock_thresh = 23'h40;
        step(1, 24'h000100, 0, 0);
        n_checks++;
        if (freq_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_t1: got v=%0b, want 0", freq_valid);
        end
        step(0, 24'h0, 0, 0);
        n_checks++;
        if (freq_valid !== 1'b1 || freq_word !== 32'h00001100) begin
            n_errors++;
            $display("FAIL basic_t2: got v=%0b w=%h, want v=1 w=00001100", freq_valid, freq_word);
        end
        step(0, 24'h0, 0, 0);
        n_checks++;
        if (freq_valid !== 1'b0 || freq_word !== 32'h00001100) begin
            n_errors++;
            $display("FAIL basic_hold: got v=%0b w=%h, want v=0 w=00001100", freq_valid, freq_word);
        end
    endtask

    task automatic test_lock();
        do_reset();
        kp_acq_sh = 4; ki_acq_sh = 8; kp_trk_sh = 10; ki_trk_sh = 14; lock_thresh = 23'h40;
        for (int i = 1; i <= 64; i++) begin
            step(1, ($urandom_range(0, 1) != 0) ? 24'h000020 : 24'hFFFFE0, 0, 0);
            n_checks++;
            if (freq_valid !== exp_fv || freq_word !== exp_fw) begin
                n_errors++;
                $display("FAIL lock_acq_out i=%0d: got v=%0b w=%h, want v=%0b w=%h", i, freq_valid, freq_word, exp_fv, exp_fw);
            end
            n_checks++;
            if (locked !== (i == 64)) begin
                n_errors++;
                $display("FAIL lock_rise i=%0d: got %0b, want %0b", i, locked, (i == 64));
            end
        end
        step(1, 24'h000020, 0, 0);
        step(0, 24'h0, 0, 0);
        n_checks++;
        if (freq_valid !== 1'b1 || freq_word !== exp_fw) begin
            n_errors++;
            $display("FAIL lock_trk_gain: got v=%0b w=%h, want v=1 w=%h", freq_valid, freq_word, exp_fw);
        end
        for (int i = 1; i <= 16; i++) begin
            step(1, 24'h001000, 0, 0);
            n_checks++;
            if (locked !== (i < 16)) begin
                n_errors++;
                $display("FAIL lock_fall i=%0d: got %0b, want %0b", i, locked, (i < 16));
            end
        end
        step(0, 24'h0, 0, 0);
        step(0, 24'h0, 0, 0);
    endtask

    task automatic test_saturation();
        logic [23:0] errs [2];
        logic [31:0] lims [2];
        errs[0] = 24'h7FFFFF; lims[0] = 32'h7FFFFFFF;
        errs[1] = 24'h800000; lims[1] = 32'h80000001;
        kp_acq_sh = 0; ki_acq_sh = 0; lock_thresh = 23'h40;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 6; i++) begin
                step(1, errs[k], 0, 0);
                n_checks++;
                if (freq_valid !== exp_fv || freq_word !== exp_fw) begin
                    n_errors++;
                    $display("FAIL sat_step k=%0d i=%0d: got v=%0b w=%h, want v=%0b w=%h", k, i, freq_valid, freq_word, exp_fv, exp_fw);
                end
            end
            step(0, 24'h0, 0, 0);
            n_checks++;
            if (freq_word !== lims[k]) begin
                n_errors++;
                $display("FAIL sat_clamp k=%0d: got %h, want %h", k, freq_word, lims[k]);
            end
        end
    endtask

    task automatic test_frz_clr();
        logic [31:0] held;
        do_reset();
        kp_acq_sh = 4; ki_acq_sh = 8; kp_trk_sh = 6; ki_trk_sh = 10; lock_thresh = 23'h200;
        for (int i = 0; i < 66; i++) begin
            step(1, 24'h000100, 0, 0);
            n_checks++;
            if (freq_valid !== exp_fv || freq_word !== exp_fw || locked !== exp_lk) begin
                n_errors++;
                $display("FAIL frz_warm i=%0d: got v=%0b w=%h lk=%0b, want v=%0b w=%h lk=%0b", i, freq_valid, freq_word, locked, exp_fv, exp_fw, exp_lk);
            end
        end
        held = '0;
        for (int i = 0; i < 5; i++) begin
            step(1, 24'h000100, 1, 0);
            if (i == 1) held = exp_fw;
            n_checks++;
            if (freq_valid !== 1'b1 || freq_word !== exp_fw || (i > 1 && freq_word !== held)) begin
                n_errors++;
                $display("FAIL frz_const i=%0d: got %h, want %h", i, freq_word, exp_fw);
            end
        end
        step(1, 24'h000100, 1, 1);
        n_checks++;
        if (freq_valid !== 1'b1 || freq_word !== 32'h00000400 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_s2: got v=%0b w=%h lk=%0b, want v=1 w=00000400 lk=0", freq_valid, freq_word, locked);
        end
        step(0, 24'h0, 0, 0);
        n_checks++;
        if (freq_valid !== 1'b1 || freq_word !== exp_fw || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_after: got v=%0b w=%h lk=%0b, want v=1 w=%h lk=0", freq_valid, freq_word, locked, exp_fw);
        end
    endtask

    task automatic test_back_to_back();
        bit pat [5];
        pat[0] = 0; pat[1] = 1; pat[2] = 1; pat[3] = 1; pat[4] = 0;
        do_reset();
        kp_acq_sh = 4; ki_acq_sh = 8; lock_thresh = 23'h0;
        for (int i = 0; i < 5; i++) begin
            step(i < 3, 24'($urandom()), 0, 0);
            n_checks++;
            if (freq_valid !== pat[i] || freq_word !== exp_fw) begin
                n_errors++;
                $display("FAIL b2b i=%0d: got v=%0b w=%h, want v=%0b w=%h", i, freq_valid, freq_word, pat[i], exp_fw);
            end
        end
        step(1, 24'h012345, 0, 0);
        step(1, 24'h054321, 0, 0);
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (freq_valid !== 1'b0 || freq_word !== 32'h0 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL async_rst: got v=%0b w=%h lk=%0b, want 0/0/0", freq_valid, freq_word, locked);
        end
        err_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 24'h0, 0, 0);
            n_checks++;
            if (freq_valid !== 1'b0 || freq_word !== 32'h0) begin
                n_errors++;
                $display("FAIL rst_no_pulse i=%0d: got v=%0b w=%h, want 0/0", i, freq_valid, freq_word);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] e;
        do_reset();
        kp_acq_sh = 5'($urandom_range(0, 12)); ki_acq_sh = 5'($urandom_range(4, 20));
        kp_trk_sh = 5'($urandom_range(6, 31)); ki_trk_sh = 5'($urandom_range(10, 31));
        lock_thresh = 23'h80;
        for (int i = 0; i < 400; i++) begin
            if (i < 150 || $urandom_range(0, 3) != 0)
                e = 24'($signed($urandom_range(0, 256)) - 128);
            else if ($urandom_range(0, 1) != 0)
                e = 24'($urandom());
            else
                e = ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
            step($urandom_range(0, 4) != 0, e,
                 (i >= 150) && ($urandom_range(0, 15) == 0),
                 (i >= 150) && ($urandom_range(0, 63) == 0));
            n_checks++;
            if (freq_valid !== exp_fv || freq_word !== exp_fw || locked !== exp_lk) begin
                n_errors++;
                $display("FAIL random i=%0d: got v=%0b w=%h lk=%0b, want v=%0b w=%h lk=%0b", i, freq_valid, freq_word, locked, exp_fv, exp_fw, exp_lk);
            end
        end
        step(0, 24'h0, 0, 0);
    endtask

    initial begin
        rst_n = 0; err_valid = 0; phase_err = '0;
        kp_acq_sh = 4; ki_acq_sh = 8; kp_trk_sh = 10; ki_trk_sh = 14;
        lock_thresh = 23'h40; integ_clr = 0; integ_frz = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_lock();
        test_saturation();
        test_frz_clr();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
